// File: rtl/vga_capture.sv
// vga_capture: recovers the pixel raster from an incoming VGA stream, checks line/frame timing and emits coordinates with each active pixel
module vga_capture #(
  parameter int H_SYNC_CYC   = 96,
  parameter int X_START      = 144,
  parameter int H_SYNC_ACT   = 640,
  parameter int H_SYNC_TOTAL = 800,
  parameter int V_SYNC_CYC   = 2,
  parameter int Y_START      = 35,
  parameter int V_SYNC_ACT   = 480,
  parameter int V_SYNC_TOTAL = 525,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        iVGA_H_SYNC,
  input  logic        iVGA_V_SYNC,
  input  logic [9:0]  iVGA_R,
  input  logic [9:0]  iVGA_G,
  input  logic [9:0]  iVGA_B,
  output logic        oPixel_valid,
  output logic [9:0]  oCoord_X,
  output logic [9:0]  oCoord_Y,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic        oFrame_start,
  output logic        oLocked,
  output logic        oH_error,
  output logic        oV_error,
  output logic [10:0] oLine_length
);
  localparam logic [10:0] XS = 11'(X_START);
  localparam logic [10:0] XE = 11'(X_START + H_SYNC_ACT);
  localparam logic [10:0] YS = 11'(Y_START);
  localparam logic [10:0] YE = 11'(Y_START + V_SYNC_ACT);
  localparam logic [10:0] HT = 11'(H_SYNC_TOTAL);
  localparam logic [10:0] VL = 11'(V_SYNC_TOTAL - 1);
  localparam int GW = LOCK_FRAMES > 1 ? $clog2(LOCK_FRAMES + 1) : 1;
  localparam logic [GW-1:0] LF = GW'(LOCK_FRAMES);
  // a sync pulse reaching into the active region makes the mode uncapturable, so it never locks
  localparam bit MODE_OK = (H_SYNC_CYC < X_START) && (V_SYNC_CYC < Y_START);

  typedef enum logic [1:0] {SEARCH, COUNT, LOCKED} state_t;

  state_t          state;
  logic [GW-1:0]   good;
  logic            hs1, hs2, vs1, vs2;
  logic [9:0]      r1, g1, b1, r2, g2, b2;
  logic [10:0]     h_cnt, v_cnt, len_q;
  logic            hf_q, h_bad_q, v_bad_q, bnd_q, seen_h, seen_v, v_pending, frame_bad;
  logic            h_fall, v_fall, bnd, tmo, err, pix_ok;

  assign h_fall = hs2 & ~hs1;
  assign v_fall = vs2 & ~vs1;
  assign bnd    = h_fall & (v_pending | v_fall);
  assign tmo    = h_cnt == '1;
  assign err    = h_bad_q | v_bad_q | tmo;
  assign pix_ok = state == LOCKED && h_cnt >= XS && h_cnt < XE && v_cnt >= YS && v_cnt < YE;

  // input registers; syncs get a second stage for falling-edge detection
  always_ff @(posedge Clock or posedge reset)
    if (reset) begin
      {hs1, hs2, vs1, vs2} <= '0;
      {r1, g1, b1} <= '0;
    end else begin
      hs1 <= iVGA_H_SYNC;
      hs2 <= hs1;
      vs1 <= iVGA_V_SYNC;
      vs2 <= vs1;
      {r1, g1, b1} <= {iVGA_R, iVGA_G, iVGA_B};
    end

  // raster counters: h_cnt/v_cnt give the position of the sample now held in r2/g2/b2
  always_ff @(posedge Clock or posedge reset)
    if (reset) begin
      {h_cnt, v_cnt, len_q} <= '0;
      {hf_q, h_bad_q, v_bad_q, bnd_q, seen_h, seen_v, v_pending} <= '0;
      {r2, g2, b2} <= '0;
    end else begin
      h_cnt     <= h_fall ? '0 : tmo ? h_cnt : h_cnt + 11'd1;
      hf_q      <= h_fall;
      len_q     <= h_cnt + 11'd1;
      h_bad_q   <= h_fall & seen_h & (h_cnt + 11'd1 != HT);
      seen_h    <= seen_h | h_fall;
      v_pending <= (v_pending | v_fall) & ~h_fall;
      v_cnt     <= bnd ? '0 : (h_fall && v_cnt != '1) ? v_cnt + 11'd1 : v_cnt;
      bnd_q     <= bnd;
      v_bad_q   <= bnd & seen_v & (v_cnt != VL);
      seen_v    <= seen_v | bnd;
      {r2, g2, b2} <= {r1, g1, b1};
    end

  // lock FSM, sticky error flags and registered pixel outputs
  always_ff @(posedge Clock or posedge reset)
    if (reset) begin
      state <= SEARCH;
      good <= '0;
      frame_bad <= 1'b0;
      {oPixel_valid, oFrame_start, oLocked, oH_error, oV_error} <= '0;
      {oCoord_X, oCoord_Y, oRed, oGreen, oBlue, oLine_length} <= '0;
    end else begin
      oLine_length <= hf_q ? len_q : oLine_length;
      oH_error     <= oH_error | h_bad_q | tmo;
      oV_error     <= oV_error | v_bad_q;
      frame_bad    <= bnd_q ? 1'b0 : frame_bad | err;
      oPixel_valid <= pix_ok;
      oCoord_X     <= pix_ok ? 10'(h_cnt - XS) : '0;
      oCoord_Y     <= pix_ok ? 10'(v_cnt - YS) : '0;
      oRed         <= pix_ok ? r2 : '0;
      oGreen       <= pix_ok ? g2 : '0;
      oBlue        <= pix_ok ? b2 : '0;
      oFrame_start <= pix_ok && h_cnt == XS && v_cnt == YS;
      case (state)
        SEARCH: if (bnd_q && MODE_OK) begin
          state <= COUNT;
          good  <= '0;
        end
        COUNT: if (bnd_q) begin
          good <= (frame_bad | err) ? '0 : good + GW'(1);
          if (!(frame_bad | err) && good + GW'(1) == LF) begin
            state   <= LOCKED;
            oLocked <= 1'b1;
          end
        end
        LOCKED: if (err) begin
          state   <= SEARCH;
          oLocked <= 1'b0;
        end
        default: begin
          state   <= SEARCH;
          oLocked <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: table of whole frames with expected lock/error/pixel results, plus reset and timeout sequences
module tb_vga_capture;
  localparam int HS = 4, XS = 6, HA = 8, HT = 16;
  localparam int VS = 2, YS = 3, VA = 4, VT = 10;

  logic        Clock = 0, reset = 1;
  logic        hs = 1, vs = 1;
  logic [9:0]  r = 0, g = 0, b = 0;
  logic        oPixel_valid, oFrame_start, oLocked, oH_error, oV_error;
  logic [9:0]  oCoord_X, oCoord_Y, oRed, oGreen, oBlue;
  logic [10:0] oLine_length;

  int checks = 0, failures = 0;
  int nval = 0, nfs = 0, data_bad = 0, zero_bad = 0, fs_bad = 0, fs_red = 0, last_x = 0, last_y = 0;

  vga_capture #(
    .H_SYNC_CYC(HS), .X_START(XS), .H_SYNC_ACT(HA), .H_SYNC_TOTAL(HT),
    .V_SYNC_CYC(VS), .Y_START(YS), .V_SYNC_ACT(VA), .V_SYNC_TOTAL(VT), .LOCK_FRAMES(2)
  ) dut (
    .Clock(Clock), .reset(reset),
    .iVGA_H_SYNC(hs), .iVGA_V_SYNC(vs), .iVGA_R(r), .iVGA_G(g), .iVGA_B(b),
    .oPixel_valid(oPixel_valid), .oCoord_X(oCoord_X), .oCoord_Y(oCoord_Y),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oFrame_start(oFrame_start),
    .oLocked(oLocked), .oH_error(oH_error), .oV_error(oV_error), .oLine_length(oLine_length)
  );

  always #5 Clock = ~Clock;

  // pin stream carries R = n, G = line, B = 1023-n, so every valid pixel can be checked against its coordinates
  always @(negedge Clock) begin
    if (oPixel_valid) begin
      nval++;
      last_x = int'(oCoord_X);
      last_y = int'(oCoord_Y);
      if (int'(oRed) != int'(oCoord_X) + XS || int'(oGreen) != int'(oCoord_Y) + YS ||
          int'(oBlue) != 1023 - (int'(oCoord_X) + XS))
        data_bad++;
    end else if ((oCoord_X | oCoord_Y | oRed | oGreen | oBlue) != 0)
      zero_bad++;
    if (oFrame_start) begin
      nfs++;
      fs_red = int'(oRed);
      if (!oPixel_valid || oCoord_X != 0 || oCoord_Y != 0) fs_bad++;
    end else if (oPixel_valid && oCoord_X == 0 && oCoord_Y == 0)
      fs_bad++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(oPixel_valid), 0);
    chk({tag, "_xy"}, int'({oCoord_X, oCoord_Y}), 0);
    chk({tag, "_rgb"}, int'({oRed, oGreen, oBlue}), 0);
    chk({tag, "_flags"}, int'({oFrame_start, oLocked, oH_error, oV_error}), 0);
    chk({tag, "_len"}, int'(oLine_length), 0);
  endtask

  task automatic drive_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge Clock); #1;
      hs = 1; vs = 1;
    end
  endtask

  task automatic drive_frame(input int lines, input int bad_line, input int bad_len, input bit vearly);
    int len;
    for (int l = 0; l < lines; l++) begin
      len = (l == bad_line) ? bad_len : HT;
      for (int n = 0; n < len; n++) begin
        @(posedge Clock); #1;
        hs = n >= HS;
        vs = !((l < VS) || (vearly && l == lines - 1 && n >= 5));
        r = 10'(n);
        g = 10'(l);
        b = 10'(1023 - n);
      end
    end
  endtask

  typedef struct {
    int lines; int bad_line; int bad_len; bit vearly;
    bit exp_locked; int exp_valids; int exp_fs; bit exp_herr; bit exp_verr;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int v0, f0, d0, z0, s0;
    tbl[0]  = '{10, -1, 0,  0, 0, 0,  0, 0, 0};
    tbl[1]  = '{10, -1, 0,  0, 0, 0,  0, 0, 0};
    tbl[2]  = '{10, -1, 0,  0, 1, 32, 1, 0, 0};
    tbl[3]  = '{10, -1, 0,  0, 1, 32, 1, 0, 0};
    tbl[4]  = '{10, 5,  15, 0, 0, 24, 1, 1, 0};
    tbl[5]  = '{10, -1, 0,  0, 0, 0,  0, 1, 0};
    tbl[6]  = '{10, -1, 0,  0, 0, 0,  0, 1, 0};
    tbl[7]  = '{10, -1, 0,  0, 1, 32, 1, 1, 0};
    tbl[8]  = '{9,  -1, 0,  0, 1, 32, 1, 1, 0};
    tbl[9]  = '{10, -1, 0,  0, 0, 0,  0, 1, 1};
    tbl[10] = '{10, -1, 0,  0, 0, 0,  0, 1, 1};
    tbl[11] = '{10, -1, 0,  0, 0, 0,  0, 1, 1};
    tbl[12] = '{10, -1, 0,  1, 1, 32, 1, 1, 1};
    tbl[13] = '{10, -1, 0,  0, 1, 32, 1, 1, 1};
    tbl[14] = '{10, -1, 0,  0, 1, 32, 1, 1, 1};

    repeat (3) @(posedge Clock);
    #1 chk_zero("reset");
    reset = 0;
    drive_idle(20);

    for (int i = 0; i < 15; i++) begin
      v0 = nval; f0 = nfs; d0 = data_bad; z0 = zero_bad; s0 = fs_bad;
      drive_frame(tbl[i].lines, tbl[i].bad_line, tbl[i].bad_len, tbl[i].vearly);
      chk($sformatf("f%0d_locked", i), int'(oLocked), int'(tbl[i].exp_locked));
      chk($sformatf("f%0d_valids", i), nval - v0, tbl[i].exp_valids);
      chk($sformatf("f%0d_fs", i), nfs - f0, tbl[i].exp_fs);
      chk($sformatf("f%0d_herr", i), int'(oH_error), int'(tbl[i].exp_herr));
      chk($sformatf("f%0d_verr", i), int'(oV_error), int'(tbl[i].exp_verr));
      chk($sformatf("f%0d_data", i), data_bad - d0, 0);
      chk($sformatf("f%0d_zero", i), zero_bad - z0, 0);
      chk($sformatf("f%0d_fspos", i), fs_bad - s0, 0);
      chk($sformatf("f%0d_len", i), int'(oLine_length), HT);
      if (tbl[i].exp_valids == HA * VA) begin
        chk($sformatf("f%0d_last", i), last_x * 100 + last_y, (HA - 1) * 100 + VA - 1);
        chk($sformatf("f%0d_red00", i), fs_red, XS);
      end
    end

    // reset in the middle of an active line while locked
    drive_frame(5, -1, 0, 0);
    chk("pre_rst_valid", int'(oPixel_valid), 1);
    #2 reset = 1;
    #1 chk_zero("mid_rst");
    @(posedge Clock); #1;
    hs = 1; vs = 1;
    @(posedge Clock); #1 reset = 0;
    drive_idle(20);
    for (int i = 0; i < 3; i++) begin
      v0 = nval;
      drive_frame(10, -1, 0, 0);
      chk($sformatf("relock%0d_locked", i), int'(oLocked), i == 2 ? 1 : 0);
      chk($sformatf("relock%0d_valids", i), nval - v0, i == 2 ? HA * VA : 0);
    end
    chk("relock_herr", int'(oH_error), 0);
    chk("relock_verr", int'(oV_error), 0);

    // H sync stuck high: timeout flags the error and drops lock
    drive_idle(2000);
    chk("pre_tmo_herr", int'(oH_error), 0);
    chk("pre_tmo_locked", int'(oLocked), 1);
    v0 = nval;
    drive_idle(100);
    chk("tmo_herr", int'(oH_error), 1);
    chk("tmo_locked", int'(oLocked), 0);
    drive_frame(10, -1, 0, 0);
    chk("tmo_valids", nval - v0, 0);
    chk("tmo_after_locked", int'(oLocked), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_capture.md
# vga_capture

Receive-side counterpart of the VGA timing generator. It samples an incoming VGA stream (active-low H/V sync plus 10-bit R/G/B) on the system clock and recovers the pixel raster from the sync edges. It checks the line and frame timing against the configured mode, then presents each active pixel with its X/Y coordinate and a valid strobe. It sits downstream of a VGA source (loopback or external) and feeds frame-capture and checking logic.

## Interface
- H_SYNC_CYC, 96: H sync pulse width, in clocks
- X_START, 144: clocks from the H sync falling edge to the first active pixel
- H_SYNC_ACT, 640: active pixels per line
- H_SYNC_TOTAL, 800: clocks per line
- V_SYNC_CYC, 2: V sync pulse width, in lines
- Y_START, 35: lines from the V sync falling edge to the first active line
- V_SYNC_ACT, 480: active lines per frame
- V_SYNC_TOTAL, 525: lines per frame
- LOCK_FRAMES, 2: consecutive good frames required to declare lock

Ports:
- Clock  in  1  system/pixel clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- iVGA_H_SYNC  in  1  horizontal sync, active low.
- iVGA_V_SYNC  in  1  vertical sync, active low.
- iVGA_R, iVGA_G, iVGA_B  in  10 each  pixel colour.
- oPixel_valid  out  1  active pixel present on the outputs this cycle.
- oCoord_X  out  10  column 0..H_SYNC_ACT-1.
- oCoord_Y  out  10  row 0..V_SYNC_ACT-1.
- oRed, oGreen, oBlue  out  10 each  captured colour.
- oFrame_start  out  1  one-cycle pulse coincident with pixel (0,0).
- oLocked  out  1  timing matches the configured mode.
- oH_error  out  1  sticky flag: line-length mismatch or H sync timeout.
- oV_error  out  1  sticky flag: frame-length mismatch.
- oLine_length  out  11  clocks between the last two H sync falling edges.

## Operation
- Input stage: all inputs are registered once. The sync signals are delayed one further stage for edge detection. Sync registers reset to 0, so no spurious edge occurs after reset.
- H fall: a registered H_SYNC sample of 0 whose previous sample was 1.
- V fall: the same rule applied to V_SYNC.
- Sample index n: count of clocks since the first low H_SYNC pin sample of the current line (n=0 on that sample).
  - Counter h_cnt is 11 bits. It is cleared on H fall, otherwise increments, and saturates at 2047.
- On H fall:
  - oLine_length <= previous h_cnt + 1.
  - If at least one earlier H fall has been seen since reset and that value is not H_SYNC_TOTAL, oH_error is set.
- Timeout: if h_cnt reaches 2047, oH_error is set.
- Line counter v_cnt is 11 bits and saturates at 2047.
  - A V fall sets v_pending.
  - At the next H fall (including an H fall in the same cycle), v_cnt <= 0 and v_pending clears. This is a frame boundary.
  - Any other H fall increments v_cnt.
- Frame boundary check: if the prior v_cnt is not V_SYNC_TOTAL-1 and at least one earlier boundary has been seen, oV_error is set.
- Lock FSM:
  - SEARCH (reset state). Go to COUNT on the first frame boundary, with good <= 0.
  - COUNT. At each boundary: if the frame just ended had no H or V mismatch, good <= good+1; otherwise good <= 0. When good reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED. oLocked = 1. Any H mismatch, H timeout or V mismatch returns to SEARCH in the same cycle the error flag sets.
- Pixel output: a pixel is valid when the FSM is LOCKED and X_START <= n < X_START+H_SYNC_ACT and Y_START <= v_cnt < Y_START+V_SYNC_ACT.
  - oCoord_X = n-X_START.
  - oCoord_Y = v_cnt-Y_START.
  - RGB is the pin sample at index n.
- When not valid, oCoord_X, oCoord_Y and the colour outputs hold 0.
- oFrame_start = oPixel_valid and X=0 and Y=0.
- Error flags stay set until reset; lock can be regained while they are set.

## Timing
- Reset values: every output is 0, the FSM is in SEARCH, and all counters are 0.
- Reset asserted mid-frame clears everything immediately. The next lock requires a fresh SEARCH.
- Latency: a pin sample taken at edge k appears on oPixel_valid, coords and colour after edge k+2. All outputs are registered.
- oLine_length and the error flags update after edge k+2 for the sample at edge k that completes the H fall.
- oLocked falls after that same edge.
- Simultaneous V fall and H fall: the line is treated as line 0 of the new frame.
- Lock point: LOCKED is entered at the (LOCK_FRAMES+1)-th frame boundary after reset, counting the first boundary. The first valid pixel is (0,0) of the frame that starts at that boundary.

## Test plan
- Nominal stream, mode defaults, R = n mod 1024:
  - oLocked rises at the 3rd frame boundary.
  - That frame gives exactly 307200 valids, the first (0,0) with oFrame_start and oRed = 144, the last (639,479).
  - oLine_length = 800; no error flags.
- One line of 799 clocks while locked -> oH_error = 1 and oLocked = 0, two clocks after that H fall. Valids stop. The stream relocks after 2 good frames; oH_error stays 1.
- Frame of 524 lines -> oV_error = 1, lock lost at the boundary, relock later.
- H sync held high for 2100 clocks -> timeout sets oH_error; no pixels while unlocked.
- Reset asserted mid-line while locked -> all outputs 0 immediately. After release the block needs 3 boundaries to relock.
- V fall one line before the H fall vs the same cycle as the H fall -> both yield v_cnt = 0 on that H fall, and Y numbering is identical.
